dm_access_ctrl: RTL
===================

// Module: dm_access_ctrl
// PURPOSE
//  Initiator side of the data-memory cs/rd/wr interface. Sits between the MEM stage and data memory.
//  Turns one load/store request (byte/half/word, signed/unsigned) into data-memory cycles on a
//  word-aligned address. Data memory is big-endian (lowest address = bits 31:24), writes on
//  posedge clk when cs&wr, reads combinationally when cs&rd, and stores full words only.
//  Sub-word stores are therefore done as read-modify-write.
// PARAMETERS
//  ADDR_W   12  byte-address width of the data memory
//  RD_WAIT  0   extra cycles cs/rd are held before read data is sampled (0..15)
// PORTS
//  clk        in   1       system clock, all state changes on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept a request (1 only in IDLE)
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid  out  1       one-cycle pulse: request complete
//  rsp_rdata  out  32      extended load data, valid while rsp_valid
//  rsp_err    out  1       valid while rsp_valid: misaligned or illegal size, no memory access made
//  dm_cs      out  1       memory chip select
//  dm_rd      out  1       memory read strobe
//  dm_wr      out  1       memory write strobe
//  dm_addr    out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  dm_din     out  32      write data to memory
//  dm_dout    in   32      read data from memory (don't-care unless cs&rd)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, wait counter 0. Outputs: req_ready=1, rsp_valid=0,
//   rsp_err=0, rsp_rdata=0, dm_cs=dm_rd=dm_wr=0, dm_addr=0, dm_din=0. No partial write survives:
//   dm_wr drops immediately.
//  Accept: in IDLE, when req_valid&req_ready at posedge. All req_* fields are registered.
//   req_* are ignored in all other states.
//  States: IDLE, RD, WR, RESP, ERR.
//   IDLE->ERR  : size==11, or half with addr[0]=1, or word with addr[1:0]!=0.
//   IDLE->RD   : any load, or byte/half store.
//   IDLE->WR   : word store.
//   RD         : drives cs=1, rd=1. Holds for RD_WAIT+1 cycles (counter). On the last cycle it
//                captures dm_dout into the word register. Then RD->RESP for a load,
//                RD->WR for a store.
//   WR         : drives cs=1, wr=1 for exactly 1 cycle. dm_din = merged word. Then ->RESP.
//   RESP, ERR  : rsp_valid=1 for 1 cycle, then ->IDLE. ERR sets rsp_err=1 and rsp_rdata=0.
//  Strobes and dm_addr are decoded from registered state only. cs/rd/wr are never set together
//   with each other's opposite strobe. All are 0 in IDLE, RESP and ERR.
//  Byte lanes (big-endian): addr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
//   Half: addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
//  Load extract: select lane, then sign- or zero-extend to 32 per req_signed. Word passes through.
//  Store merge: replace only the addressed lane(s) of the captured word with req_wdata[7:0] or
//   [15:0]. Other bytes are rewritten unchanged.
//  Latency from accept edge to rsp_valid (RD_WAIT=0): sw 2, lw/lb/lh 2, sb/sh 3, error 1 cycles.
//   Back-to-back requests: next accept occurs the cycle after rsp_valid.
//  Address wrap: there is none. Aligned address never exceeds 2^ADDR_W-4.
// TESTING
//  1. reset_n low mid-WR of sb -> dm_wr=0 same cycle, memory word unchanged, req_ready=1.
//  2. sw addr 0x010 data 0xDEADBEEF, then lw 0x010 -> one wr cycle with dm_addr 0x010,
//     rsp_rdata 0xDEADBEEF, lw latency 2.
//  3. mem[0x010]=0xDEADBEEF; lb 0x011 -> 0xFFFFFFAD; lbu 0x011 -> 0x000000AD;
//     lh 0x012 -> 0xFFFFBEEF; lhu 0x010 -> 0x0000DEAD.
//  4. mem[0x020]=0x11223344; sb 0x022 data 0xAB -> 0x1122AB44; sh 0x020 data 0x5566 -> 0x5566AB44;
//     each sb/sh takes exactly one rd cycle then one wr cycle.
//  5. lw 0x013, sh 0x021, size=11 -> rsp_err=1, rsp_rdata=0, dm_cs never asserted, latency 1.
//  6. RD_WAIT=3: lw -> cs/rd held 4 cycles, latency 5. Continuous req_valid gives accepts
//     only in IDLE.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Request/response and data-memory signal bundle for the data-memory access controller.
// master: the controller view (takes requests, returns responses, drives the memory strobes).
// slave : the environment view (pipeline MEM stage issuing requests plus the data memory itself).
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 12
);
    // request from MEM stage
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    // response to MEM stage
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    // data-memory bus
    logic              dm_cs;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output dm_cs, dm_rd, dm_wr, dm_addr, dm_din,
        input  dm_dout
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  dm_cs, dm_rd, dm_wr, dm_addr, dm_din,
        output dm_dout
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Purpose: turns one byte/half/word load/store into word-aligned big-endian data-memory cycles (sub-word stores as read-modify-write).
// Latency: accept edge to rsp_valid = 1 (error), 2 (load, word store), 3 (byte/half store), plus RD_WAIT for any read phase.
// Backpressure: req_ready is high only in IDLE; one request in flight, next accept the cycle after rsp_valid.
//
// Ports: clk, reset_n (async, active-low) plus bus (dm_access_ctrl_if.master):
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata  request in
//   rsp_valid/rsp_rdata/rsp_err                                        one-cycle response pulse
//   dm_cs/dm_rd/dm_wr/dm_addr/dm_din/dm_dout                           data-memory bus
module dm_access_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int RD_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dm_access_ctrl_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;

    logic              req_illegal;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // Illegal size or misalignment is decided on the live request so the FSM can go straight to ERR.
    always_comb begin
        req_illegal = 1'b0;
        case (bus.req_size)
            2'b01:   req_illegal = bus.req_addr[0];
            2'b10:   req_illegal = (bus.req_addr[1:0] != 2'b00);
            2'b11:   req_illegal = 1'b1;
            default: req_illegal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'd0;
                    if (req_illegal) begin
                        state_d = S_ERR;
                    end else if (bus.req_we && bus.req_size == 2'b10) begin
                        // Full-word store needs no read of the old word.
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    word_d  = bus.dm_dout;
                    cnt_d   = 4'd0;
                    state_d = we_q ? S_WR : S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
        end
    end

    // Big-endian lane select and extension of the captured word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = word_q[31:24];
            2'd1:    lane_b = word_q[23:16];
            2'd2:    lane_b = word_q[15:8];
            default: lane_b = word_q[7:0];
        endcase
        lane_h = addr_q[1] ? word_q[15:0] : word_q[31:16];
        case (size_q)
            2'b00:   load_ext = {{24{sgn_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{sgn_q & lane_h[15]}}, lane_h};
            default: load_ext = word_q;
        endcase
    end

    // Store merge: only the addressed lane(s) change, the rest of the old word is written back.
    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
                else           merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // All outputs decode from registered state, so an async reset kills dm_wr at once.
    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
        bus.rsp_err   = (state_q == S_ERR);
        bus.rsp_rdata = (state_q == S_RESP && !we_q) ? load_ext : 32'd0;
        bus.dm_cs     = (state_q == S_RD) || (state_q == S_WR);
        bus.dm_rd     = (state_q == S_RD);
        bus.dm_wr     = (state_q == S_WR);
        bus.dm_addr   = bus.dm_cs ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus.dm_din    = (state_q == S_WR) ? merged : 32'd0;
    end

endmodule
